// File: rtl/muldiv_pkg.sv
// Opcode set shared with the integer ALU, FSM state type and the
// accept-time special-case detector used by muldiv_unit.
package muldiv_pkg;

  localparam int unsigned OP_BITS = 5;

  localparam logic [OP_BITS-1:0] OP_ADD    = 5'h00;
  localparam logic [OP_BITS-1:0] OP_SUB    = 5'h01;
  localparam logic [OP_BITS-1:0] OP_AND    = 5'h02;
  localparam logic [OP_BITS-1:0] OP_OR     = 5'h03;
  localparam logic [OP_BITS-1:0] OP_MUL    = 5'h10;
  localparam logic [OP_BITS-1:0] OP_MULH   = 5'h11;
  localparam logic [OP_BITS-1:0] OP_MULHSU = 5'h12;
  localparam logic [OP_BITS-1:0] OP_MULHU  = 5'h13;
  localparam logic [OP_BITS-1:0] OP_DIV    = 5'h14;
  localparam logic [OP_BITS-1:0] OP_DIVU   = 5'h15;
  localparam logic [OP_BITS-1:0] OP_REM    = 5'h16;
  localparam logic [OP_BITS-1:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic is_m_op(input logic [OP_BITS-1:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_div_op(input logic [OP_BITS-1:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem_op(input logic [OP_BITS-1:0] op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // Operands arrive zero-extended to 64 bits so one function serves any XLEN.
  function automatic logic is_special(input logic [OP_BITS-1:0] op,
                                      input logic [63:0]        a,
                                      input logic [63:0]        b,
                                      input int unsigned        xlen);
    logic [63:0] ones;
    logic [63:0] min_neg;
    logic        sdiv;
    ones    = (xlen >= 64) ? '1 : ((64'd1 << xlen) - 64'd1);
    min_neg = 64'd1 << (xlen - 1);
    sdiv    = op inside {OP_DIV, OP_REM};
    return !is_m_op(op)
        || (is_div_op(op) && (b == '0))
        || (sdiv && (a == min_neg) && (b == ones));
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the EX-stage issue logic and muldiv_unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5
);
  logic            FLUSH;
  logic            IN_VALID;
  logic            IN_READY;
  logic [OPW-1:0]  OPCODE;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] RESULT;
  logic            BUSY;

  modport master (
    output FLUSH, IN_VALID, OPCODE, DATA1, DATA2, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, BUSY
  );

  modport slave (
    input  FLUSH, IN_VALID, OPCODE, DATA1, DATA2, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, BUSY
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per step,
// XLEN+1-bit remainder register, quotient shifts in as the dividend shifts out.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN-1:0] restored;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The trial difference is always stored; a negative one is restored on the
  // following step (and on the output), so the sign bit is the restore flag.
  always_comb begin
    restored = rem_q[XLEN] ? XLEN'(rem_q + {1'b0, dvsr_q}) : rem_q[XLEN-1:0];
    shifted  = {restored, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else if (load) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q  <= diff;
      quo_q  <= {quo_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

  assign quotient  = quo_q;
  assign remainder = restored;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready on both sides.
// Define MULDIV_FAST_MUL_EN for a registered single-stage multiplier (IDLE->FIX->DONE).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5
) (
  input  logic     CLK,
  input  logic     RESETN,
  muldiv_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN);
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [OP_BITS-1:0]  op_q, op_in;
  logic [OPW-1:0]      opcode;
  logic                neg_q, rem_neg_q;
  logic [2*XLEN-1:0]   acc_q, acc_load, prod;
  logic [XLEN-1:0]     mcand_q, result_q, fix_res, spec_res;
  logic [XLEN-1:0]     mag1, mag2, quo, rem, quo_s, rem_s;
  logic [XLEN:0]       mul_sum;
  logic [63:0]         a64, b64;
  logic                s1, s2, neg1, neg2, special, accept, div_step, mul_step;

  assign opcode = bus.OPCODE;
  assign accept = bus.IN_VALID && bus.IN_READY && !bus.FLUSH;

  always_comb begin
    op_in = OP_BITS'(opcode);
    s1    = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s2    = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    neg1  = s1 && bus.DATA1[XLEN-1];
    neg2  = s2 && bus.DATA2[XLEN-1];
    mag1  = neg1 ? -bus.DATA1 : bus.DATA1;
    mag2  = neg2 ? -bus.DATA2 : bus.DATA2;
    a64   = '0;
    b64   = '0;
    a64[XLEN-1:0] = bus.DATA1;
    b64[XLEN-1:0] = bus.DATA2;
    special  = is_special(op_in, a64, b64, XLEN);
    spec_res = '0;
    if (is_m_op(op_in)) begin
      if (bus.DATA2 == '0) spec_res = is_rem_op(op_in) ? bus.DATA1 : '1;
      else                 spec_res = (op_in == OP_DIV) ? bus.DATA1 : '0;
    end
`ifdef MULDIV_FAST_MUL_EN
    acc_load = (2*XLEN)'(mag1) * (2*XLEN)'(mag2);
`else
    acc_load = {{XLEN{1'b0}}, mag2};
`endif
  end

  always_comb begin
    div_step = (state_q == CALC) && is_div_op(op_q);
    mul_step = (state_q == CALC) && !is_div_op(op_q);
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    prod     = neg_q ? -acc_q : acc_q;
    quo_s    = neg_q ? -quo : quo;
    rem_s    = rem_neg_q ? -rem : rem;
    unique case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_s;
      default:                      fix_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (special)                          state_d = DONE;
          else if (FAST_MUL && !is_div_op(op_in)) state_d = FIX;
          else                                  state_d = CALC;
        end
      end
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (bus.OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.FLUSH) state_d = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_in;
        neg_q     <= neg1 ^ neg2;
        rem_neg_q <= neg1;
        cnt_q     <= CW'(XLEN - 1);
        mcand_q   <= mag1;
        acc_q     <= acc_load;
        if (special) result_q <= spec_res;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CW'(1);
        if (mul_step) acc_q <= {mul_sum, acc_q[XLEN-1:1]};
      end
      if (state_q == FIX) result_q <= fix_res;
    end
  end

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (CLK),
    .rst_n     (RESETN),
    .load      (accept),
    .step      (div_step),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quo),
    .remainder (rem)
  );

  assign bus.IN_READY  = (state_q == IDLE);
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.OUT_VALID = (state_q == DONE);
  assign bus.RESULT    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table, back-pressure,
// flush and reset sequences, then random ops against a 64-bit arithmetic reference.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  muldiv_if #(.XLEN(32), .OPW(5)) bus ();

  muldiv_unit #(.XLEN(32), .OPW(5)) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  // Reference: plain 64-bit arithmetic plus the RISC-V divide corner rules.
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      OP_MUL:    begin p = sa * sb;           return p[31:0];  end
      OP_MULH:   begin p = sa * sb;           return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin pu = ua * ub;          return pu[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      OP_REMU: begin
        if (b == 32'd0) return a;
        pu = ua % ub; return pu[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    bit is_mul, is_div, ovf;
    is_mul = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    is_div = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    ovf    = ((op == OP_DIV) || (op == OP_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    if (is_mul) return MUL_LAT;
    if (is_div && b != 32'd0 && !ovf) return DIV_LAT;
    return 1;
  endfunction

  // Called in the cycle right after the accept edge; lat counts cycles from it.
  task automatic wait_done(output logic [31:0] res, output int lat);
    lat = 1;
    while (bus.OUT_VALID !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (bus.OUT_VALID !== 1'b1) lat = -1;
    res = bus.RESULT;
  endtask

  task automatic handshake();
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    bus.OUT_READY = 1'b0;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bus.OPCODE   = op;
    bus.DATA1    = a;
    bus.DATA2    = b;
    bus.IN_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    wait_done(res, lat);
    handshake();
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.OPCODE   = op;
    bus.DATA1    = a;
    bus.DATA2    = b;
    bus.IN_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.IN_VALID = 1'b0;
  endtask

  logic [31:0] res, held, rb;
  logic [4:0]  ops[8];
  logic [4:0]  rop;
  logic [31:0] ra;
  int          lat, bad;

  initial begin
    resetn        = 1'b0;
    bus.FLUSH     = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.OPCODE    = '0;
    bus.DATA1     = '0;
    bus.DATA2     = '0;
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    repeat (3) @(negedge clk);
    check("reset_in_ready",  32'(bus.IN_READY),  32'd1);
    check("reset_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("reset_busy",      32'(bus.BUSY),      32'd0);
    check("reset_result",    bus.RESULT,         32'd0);
    resetn = 1'b1;
    @(negedge clk);

    add_vec(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, "div_m7_2");
    add_vec(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, "rem_m7_2");
    add_vec(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,       "divu_by0");
    add_vec(OP_REMU,   32'd5,         32'd0,         32'd5,         1,       "remu_by0");
    add_vec(OP_DIV,    32'd16,        32'd0,         32'hFFFF_FFFF, 1,       "div_by0");
    add_vec(OP_REM,    32'd16,        32'd0,         32'd16,        1,       "rem_by0");
    add_vec(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,       "div_ovf");
    add_vec(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,       "rem_ovf");
    add_vec(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1_2");
    add_vec(OP_MULHU,  32'hFFFF_FFFF, 32'd2,         32'd1,         MUL_LAT, "mulhu_ff_2");
    add_vec(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min_min");
    add_vec(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7_m3");
    add_vec(OP_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT, "divu_100_7");
    add_vec(OP_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT, "remu_100_7");
    add_vec(OP_ADD,    32'd5,         32'd6,         32'd0,         1,       "non_m_op");

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check(vecs[i].name, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: result held, second request waits for the handshake.
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    bus.OPCODE   = OP_DIVU;
    bus.DATA1    = 32'd100;
    bus.DATA2    = 32'd7;
    bus.IN_VALID = 1'b1;
    wait_done(res, lat);
    check("stall_first_lat", 32'(lat), 32'(DIV_LAT));
    held = bus.RESULT;
    bad  = 0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (bus.RESULT !== held || bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0 ||
          bus.BUSY !== 1'b1) bad++;
      if (k < 5) @(negedge clk);
    end
    check("stall_hold", 32'(bad), 32'd0);
    check("stall_result", held, 32'hFFFF_FFFD);
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    bus.OUT_READY = 1'b0;
    check("stall_ready_after_hs", 32'(bus.IN_READY), 32'd1);
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    check("stall_second_accepted", 32'(bus.IN_READY), 32'd0);
    wait_done(res, lat);
    check("stall_second_result", res, 32'd14);
    check("stall_second_lat", 32'(lat), 32'(DIV_LAT));
    handshake();

    // FLUSH in cycle T+10 of a divide.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.FLUSH = 1'b1;
    @(negedge clk);
    bus.FLUSH = 1'b0;
    check("flush_idle", 32'(bus.IN_READY), 32'd1);
    check("flush_busy", 32'(bus.BUSY), 32'd0);
    bad = 0;
    repeat (40) begin
      if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) bad++;
      @(negedge clk);
    end
    check("flush_no_valid", 32'(bad), 32'd0);

    // A request coinciding with FLUSH is dropped.
    bus.OPCODE = OP_DIV; bus.DATA1 = 32'd9; bus.DATA2 = 32'd3;
    bus.IN_VALID = 1'b1;
    bus.FLUSH    = 1'b1;
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    bus.FLUSH    = 1'b0;
    check("flush_blocks_accept", 32'(bus.IN_READY), 32'd1);
    run_op(OP_DIV, 32'd1000, 32'd3, res, lat);
    check("after_flush_div", res, 32'd333);

    // RESETN low in cycle T+10 with a non-zero RESULT pending from earlier.
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("mulhu_max", res, 32'hFFFF_FFFE);
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rst_mid_in_ready",  32'(bus.IN_READY),  32'd1);
    check("rst_mid_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_mid_busy",      32'(bus.BUSY),      32'd0);
    check("rst_mid_result",    bus.RESULT,         32'd0);
    bad = 0;
    repeat (40) begin
      if (bus.OUT_VALID !== 1'b0) bad++;
      @(negedge clk);
    end
    check("rst_mid_no_valid", 32'(bad), 32'd0);

    for (int unsigned i = 0; i < 150; i++) begin
      rop = ops[$urandom_range(0, 7)];
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(rop, ra, rb, res, lat);
      check($sformatf("rand%0d_op%0h_%08h_%08h", i, rop, ra, rb), res, ref_result(rop, ra, rb));
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(ref_latency(rop, ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
